// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and defaults for the cache-line memory arbiter
package mem_pkg;

  localparam int BEATS_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    OWN_IC,
    OWN_DC
  } state_t;

  typedef enum logic {
    OWNER_IC,
    OWNER_DC
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache request, response and memory bus signals of the arbiter
interface mem_arbiter_if;

  logic        ic_req;
  logic [31:2] ic_addr;
  logic        ic_gnt;
  logic        ic_rvalid;
  logic        ic_done;

  logic        dc_req;
  logic        dc_we;
  logic [31:2] dc_addr;
  logic [31:0] dc_wdata;
  logic        dc_gnt;
  logic        dc_rvalid;
  logic        dc_done;
  logic        dc_wnext;

  logic [31:0] arb_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:2] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  // master is the arbiter itself; slave is the surrounding caches and memory
  modport master (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, bus_ack, bus_rdata,
    output ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done, dc_wnext,
    output arb_rdata, bus_req, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, bus_ack, bus_rdata,
    input  ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done, dc_wnext,
    input  arb_rdata, bus_req, bus_we, bus_addr, bus_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter granting whole cache-line bursts to icache or dcache
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int BEATS = BEATS_DEFAULT
) (
  input logic           clk_core,
  input logic           reset_n,
  mem_arbiter_if.master arb
);

  localparam int BW = $clog2(BEATS);

  state_t         state;
  owner_t         last_owner;
  logic [29-BW:0] line;
  logic           we;
  logic [BW-1:0]  beat;

  logic own_ic;
  logic own_dc;
  logic active;
  logic ack;
  logic last_beat;

  assign own_ic    = (state == OWN_IC);
  assign own_dc    = (state == OWN_DC);
  assign active    = own_ic || own_dc;
  assign ack       = active && arb.bus_ack;
  assign last_beat = (beat == BW'(BEATS - 1));

  // Requests are only sampled in IDLE, so a burst always runs to completion
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      state      <= IDLE;
      beat       <= '0;
      last_owner <= OWNER_DC;
      line       <= '0;
      we         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          beat <= '0;
          if (arb.ic_req && (!arb.dc_req || last_owner == OWNER_DC)) begin
            state      <= OWN_IC;
            last_owner <= OWNER_IC;
            line       <= arb.ic_addr[31:2+BW];
            we         <= 1'b0;
          end else if (arb.dc_req) begin
            state      <= OWN_DC;
            last_owner <= OWNER_DC;
            line       <= arb.dc_addr[31:2+BW];
            we         <= arb.dc_we;
          end
        end
        OWN_IC, OWN_DC: begin
          if (arb.bus_ack) begin
            beat <= beat + BW'(1);
            if (last_beat) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign arb.ic_gnt    = own_ic;
  assign arb.dc_gnt    = own_dc;
  assign arb.bus_req   = active;
  assign arb.bus_we    = active && we;
  assign arb.bus_addr  = active ? {line, beat} : '0;
  assign arb.bus_wdata = (own_dc && we) ? arb.dc_wdata : '0;

  // Read data is forwarded straight from the bus on the ack cycle
  assign arb.arb_rdata = (ack && !we) ? arb.bus_rdata : '0;
  assign arb.ic_rvalid = own_ic && arb.bus_ack;
  assign arb.ic_done   = own_ic && arb.bus_ack && last_beat;
  assign arb.dc_rvalid = own_dc && arb.bus_ack && !we;
  assign arb.dc_wnext  = own_dc && arb.bus_ack && we;
  assign arb.dc_done   = own_dc && arb.bus_ack && last_beat;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

  localparam int BEATS = 4;

  logic clk_core = 1'b0;
  logic reset_n  = 1'b0;

  mem_arbiter_if ifc ();

  mem_arbiter #(.BEATS(BEATS)) dut (
    .clk_core(clk_core),
    .reset_n (reset_n),
    .arb     (ifc)
  );

  always #5 clk_core = ~clk_core;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  // Model: current owner (0 none, 1 icache, 2 dcache), line base, acks so far, write flag
  int          m_own  = 0;
  int          m_last = 2;
  int          m_k    = 0;
  logic        m_we   = 1'b0;
  logic [31:2] m_base = '0;

  initial begin
    logic        ack;
    logic        e_ic_gnt, e_dc_gnt, e_req, e_we, e_ic_rv, e_dc_rv, e_ic_done, e_dc_done, e_wnext;
    logic [31:2] e_addr;
    logic [31:0] e_wdata, e_rdata;
    @(posedge clk_core);
    forever begin
      @(negedge clk_core);
      ack = ifc.bus_ack;
      {e_ic_gnt, e_dc_gnt, e_req, e_we, e_ic_rv, e_dc_rv, e_ic_done, e_dc_done, e_wnext} = '0;
      e_addr = '0; e_wdata = '0; e_rdata = '0;
      if (m_own != 0) begin
        e_req    = 1'b1;
        e_we     = m_we;
        e_addr   = m_base + 30'(m_k);
        e_ic_gnt = (m_own == 1);
        e_dc_gnt = (m_own == 2);
        if (m_own == 2 && m_we) e_wdata = ifc.dc_wdata;
        if (ack) begin
          if (m_we) e_wnext = 1'b1;
          else begin
            e_rdata = ifc.bus_rdata;
            if (m_own == 1) e_ic_rv = 1'b1; else e_dc_rv = 1'b1;
          end
          if (m_k == BEATS - 1) begin
            if (m_own == 1) e_ic_done = 1'b1; else e_dc_done = 1'b1;
          end
        end
      end
      chk("ic_gnt", 32'(ifc.ic_gnt), 32'(e_ic_gnt));
      chk("dc_gnt", 32'(ifc.dc_gnt), 32'(e_dc_gnt));
      chk("bus_req", 32'(ifc.bus_req), 32'(e_req));
      chk("bus_we", 32'(ifc.bus_we), 32'(e_we));
      chk("bus_addr", 32'(ifc.bus_addr), 32'(e_addr));
      chk("bus_wdata", ifc.bus_wdata, e_wdata);
      chk("arb_rdata", ifc.arb_rdata, e_rdata);
      chk("ic_rvalid", 32'(ifc.ic_rvalid), 32'(e_ic_rv));
      chk("dc_rvalid", 32'(ifc.dc_rvalid), 32'(e_dc_rv));
      chk("ic_done", 32'(ifc.ic_done), 32'(e_ic_done));
      chk("dc_done", 32'(ifc.dc_done), 32'(e_dc_done));
      chk("dc_wnext", 32'(ifc.dc_wnext), 32'(e_wnext));
      // inputs are stable until the next rising edge, so advance the model now
      if (!reset_n) begin
        m_own = 0; m_k = 0; m_last = 2;
      end else if (m_own == 0) begin
        if (ifc.ic_req && ifc.dc_req) m_own = (m_last == 1) ? 2 : 1;
        else if (ifc.ic_req) m_own = 1;
        else if (ifc.dc_req) m_own = 2;
        if (m_own != 0) begin
          m_base = ((m_own == 1) ? ifc.ic_addr : ifc.dc_addr) & ~30'(BEATS - 1);
          m_we   = (m_own == 2) ? ifc.dc_we : 1'b0;
          m_k    = 0;
          m_last = m_own;
        end
      end else if (ack) begin
        m_k++;
        if (m_k == BEATS) m_own = 0;
      end
    end
  end

  task automatic drain();
    int c;
    for (c = 0; c < 20; c++) begin
      @(negedge clk_core);
      if (!ifc.bus_req) break;
      step();
    end
    chk("drain_timeout", 32'(c < 20), 32'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, first, done_n, ng, ic_done_c, we_bad;
    int          own_seq[3];
    int          gnt_c[3];
    logic        prev_ic, prev_dc, wn;
    logic [31:2] a[4];
    logic [31:0] d[4];

    ifc.ic_req = 0; ifc.ic_addr = '0; ifc.dc_req = 0; ifc.dc_we = 0;
    ifc.dc_addr = '0; ifc.dc_wdata = '0; ifc.bus_ack = 0; ifc.bus_rdata = '0;
    repeat (3) step();
    @(negedge clk_core);
    chk("reset_bus_req", 32'(ifc.bus_req), 32'd0);
    chk("reset_bus_addr", 32'(ifc.bus_addr), 32'd0);
    step();
    reset_n = 1;

    // Lone icache read, ack every cycle
    ifc.ic_req = 1; ifc.ic_addr = 30'h43; ifc.bus_ack = 1; ifc.bus_rdata = 32'h1111_0000;
    n = 0; first = -1; done_n = -1;
    for (int c = 1; c <= 20 && done_n < 0; c++) begin
      @(negedge clk_core);
      if (ifc.ic_gnt && first < 0) first = c;
      if (ifc.ic_rvalid) begin
        if (n < 4) a[n] = ifc.bus_addr;
        n++;
      end
      if (ifc.ic_done) done_n = n;
      step();
      ifc.ic_req = 0;
      ifc.bus_rdata = ifc.bus_rdata + 32'h0101;
    end
    chk("t1_first_gnt_cycle", 32'(first), 32'd2);
    chk("t1_rvalid_count", 32'(n), 32'd4);
    chk("t1_done_on_4th", 32'(done_n), 32'd4);
    for (int i = 0; i < 4; i++) chk("t1_addr", 32'(a[i]), 32'h40 + 32'(i));
    @(negedge clk_core);
    chk("t1_idle_gap", 32'({ifc.ic_gnt, ifc.bus_req}), 32'd0);
    step();

    // Tie after reset: IC, then DC after a gap, then IC
    reset_n = 0; step(); step(); reset_n = 1;
    ifc.ic_req = 1; ifc.dc_req = 1; ifc.dc_we = 0;
    ifc.ic_addr = 30'h100; ifc.dc_addr = 30'h208; ifc.bus_ack = 1;
    ng = 0; ic_done_c = -1; prev_ic = 0; prev_dc = 0;
    for (int c = 1; c <= 40 && ng < 3; c++) begin
      @(negedge clk_core);
      if (ifc.ic_gnt && !prev_ic) begin own_seq[ng] = 1; gnt_c[ng] = c; ng++; end
      if (ifc.dc_gnt && !prev_dc) begin own_seq[ng] = 2; gnt_c[ng] = c; ng++; end
      if (ifc.ic_done && ic_done_c < 0) ic_done_c = c;
      prev_ic = ifc.ic_gnt; prev_dc = ifc.dc_gnt;
      step();
    end
    ifc.ic_req = 0; ifc.dc_req = 0;
    chk("t2_grant_count", 32'(ng), 32'd3);
    chk("t2_first_ic", 32'(own_seq[0]), 32'd1);
    chk("t2_second_dc", 32'(own_seq[1]), 32'd2);
    chk("t2_third_ic", 32'(own_seq[2]), 32'd1);
    chk("t2_one_idle_gap", 32'(gnt_c[1]), 32'(ic_done_c + 2));
    drain();

    // dcache write-back with ack on alternate cycles
    ifc.dc_req = 1; ifc.dc_we = 1; ifc.dc_addr = 30'h802; ifc.dc_wdata = 32'hA000_0000;
    ifc.bus_ack = 0; n = 0; we_bad = 0;
    for (int c = 1; c <= 30 && n < 4; c++) begin
      @(negedge clk_core);
      if (ifc.dc_gnt && !ifc.bus_we) we_bad++;
      wn = ifc.dc_wnext;
      if (wn) begin
        a[n] = ifc.bus_addr; d[n] = ifc.bus_wdata;
        n++;
      end
      step();
      ifc.dc_req = 0;
      if (wn) ifc.dc_wdata = ifc.dc_wdata + 1;
      ifc.bus_ack = ~ifc.bus_ack;
    end
    ifc.bus_ack = 0; ifc.dc_we = 0;
    chk("t3_wnext_count", 32'(n), 32'd4);
    chk("t3_bus_we_held", 32'(we_bad), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t3_addr", 32'(a[i]), 32'h800 + 32'(i));
      chk("t3_wdata", d[i], 32'hA000_0000 + 32'(i));
    end
    drain();

    // Requester drops req and moves addr mid-line
    ifc.ic_req = 1; ifc.ic_addr = 30'h205; ifc.bus_ack = 1; ifc.bus_rdata = 32'h5555_0000;
    n = 0;
    for (int c = 1; c <= 30 && n < 4; c++) begin
      @(negedge clk_core);
      wn = ifc.ic_rvalid;
      if (wn) begin a[n] = ifc.bus_addr; n++; end
      step();
      if (wn) begin ifc.ic_req = 0; ifc.ic_addr = 30'h999; end
      ifc.bus_ack = ~ifc.bus_ack;
    end
    ifc.bus_ack = 0;
    chk("t4_rvalid_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) chk("t4_addr", 32'(a[i]), 32'h204 + 32'(i));
    drain();

    // Reset in the middle of a dcache read
    ifc.dc_req = 1; ifc.dc_we = 0; ifc.dc_addr = 30'h40c; ifc.bus_ack = 1; ifc.bus_rdata = 32'h7777_0000;
    n = 0;
    for (int c = 1; c <= 20 && n < 2; c++) begin
      @(negedge clk_core);
      if (ifc.dc_rvalid) n++;
      if (n < 2) step();
    end
    chk("t5_two_beats", 32'(n), 32'd2);
    step();
    reset_n = 0; ifc.dc_req = 0; ifc.ic_req = 1; ifc.ic_addr = 30'h30;
    @(negedge clk_core);
    step();
    @(negedge clk_core);
    chk("t5_rst_gnt", 32'({ifc.ic_gnt, ifc.dc_gnt, ifc.bus_req, ifc.bus_we}), 32'd0);
    chk("t5_rst_flags", 32'({ifc.ic_rvalid, ifc.dc_rvalid, ifc.ic_done, ifc.dc_done, ifc.dc_wnext}), 32'd0);
    chk("t5_rst_addr", 32'(ifc.bus_addr), 32'd0);
    chk("t5_rst_rdata", ifc.arb_rdata, 32'd0);
    chk("t5_rst_wdata", ifc.bus_wdata, 32'd0);
    step();
    reset_n = 1;
    first = -1;
    for (int c = 1; c <= 10 && first < 0; c++) begin
      @(negedge clk_core);
      if (ifc.ic_gnt) begin first = c; chk("t5_new_beat0_addr", 32'(ifc.bus_addr), 32'h30); end
      step();
      ifc.ic_req = 0;
    end
    chk("t5_new_grant", 32'(first), 32'd2);
    drain();

    // bus_ack while idle is ignored
    ifc.bus_ack = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_core);
      chk("t6_idle_ack", 32'({ifc.ic_rvalid, ifc.dc_rvalid, ifc.ic_done, ifc.dc_done, ifc.bus_req}), 32'd0);
      step();
    end
    ifc.bus_ack = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: BEATS, 4, words per cache-line transaction; power of two, 2..16.
REQ-002 clk_core  in  1  core clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset; synchronous, active-low.
REQ-004 ic_req  in  1  icache requests a line read.
REQ-005 ic_addr  in  [31:2]  icache word address; low log2(BEATS) bits ignored.
REQ-006 ic_gnt  out  1  icache owns the bus.
REQ-007 ic_rvalid  out  1  arb_rdata holds a valid icache beat.
REQ-008 ic_done  out  1  icache transaction finished; one-cycle pulse.
REQ-009 dc_req  in  1  dcache requests a line transaction.
REQ-010 dc_we  in  1  dcache transaction is a write-back.
REQ-011 dc_addr  in  [31:2]  dcache word address; low log2(BEATS) bits ignored.
REQ-012 dc_wdata  in  32  current write-back beat.
REQ-013 dc_gnt, dc_rvalid, dc_done  out  1 each  dcache equivalents of REQ-006..008.
REQ-014 dc_wnext  out  1  current dc_wdata consumed; present next beat.
REQ-015 arb_rdata  out  32  read data; broadcast to both caches.
REQ-016 bus_req, bus_we  out  1 each  beat request; write flag.
REQ-017 bus_addr  out  [31:2]  beat word address.
REQ-018 bus_wdata  out  32  write beat data.
REQ-019 bus_ack  in  1  beat accepted/completed this cycle.
REQ-020 bus_rdata  in  32  read data; valid when bus_ack.

Function
REQ-021 Three states: IDLE, OWN_IC, OWN_DC.
REQ-022 IDLE with exactly one req -> grant that requester next cycle.
REQ-023 IDLE with both reqs -> grant the one not in register last_owner (round-robin).
REQ-024 On leaving IDLE, latch base = addr with low log2(BEATS) bits cleared, we (dc_we, or 0 for icache), owner; zero beat counter; set last_owner.
REQ-025 Latency: req sampled high in IDLE at edge N; gnt and bus_req high from edge N+1.
REQ-026 In OWN_*: owner gnt=1, bus_req=1, bus_addr=base|beat, bus_we=latched we.
REQ-027 In OWN_DC with write: bus_wdata=dc_wdata.
REQ-028 In OWN_* without bus_ack: hold all bus outputs.
REQ-029 bus_ack, read: arb_rdata=bus_rdata combinationally; owner rvalid=1 same cycle.
REQ-030 bus_ack, write: dc_wnext=1 same cycle.
REQ-031 bus_ack: beat counter increments.
REQ-032 bus_ack with beat==BEATS-1: owner done=1 same cycle; IDLE next edge.
REQ-033 After done, at least one IDLE cycle (bus_req=0) before the next grant.
REQ-034 Changes to req, addr or we during OWN_* are ignored; a transaction cannot be aborted except by reset.
REQ-035 Outputs for the non-owner and in IDLE: gnt, rvalid, done, wnext all 0.
REQ-036 bus_ack in IDLE is ignored.

Reset
REQ-037 reset_n low at an edge -> IDLE, beat=0, last_owner=DC, at any time including mid-transaction.
REQ-038 During and after reset, until the next grant: all gnt/rvalid/done/wnext/bus_req/bus_we = 0; bus_addr, bus_wdata, arb_rdata = 0.

Structure
REQ-039 Shared package mem_pkg: state enum (IDLE, OWN_IC, OWN_DC), owner type, default BEATS constant.
REQ-040 Single module, no sub-modules; FSM, beat counter and latches live in mem_arbiter.

Verification
REQ-041 Lone icache read: ic_req=1, ic_addr=0x100>>2|3, ack every cycle -> gnt next cycle; bus_addr 0x40..0x43; 4 ic_rvalid; ic_done on the 4th ack.
REQ-042 Tie after reset: both req the same cycle -> IC granted first (last_owner=DC); DC granted after the 1-cycle idle gap; next tie -> IC.
REQ-043 dcache write-back, ack on alternate cycles -> bus_we=1; bus_addr and bus_wdata held between acks; dc_wnext exactly on ack cycles; 4 total.
REQ-044 Requester drops req and changes addr mid-line -> transaction completes on the original base; beat count unchanged.
REQ-045 reset_n low after beat 2 of an OWN_DC transaction -> all outputs 0 next edge; a new ic_req is then granted with beat=0.
REQ-046 bus_ack high while IDLE with no req -> no rvalid, done or state change.
